// File: rtl/uart_alu_interface_if.sv
// Bundle of the receive/transmit handshake and ALU bus signals around the
// UART-to-ALU sequencer. The sequencer uses the slave view. The environment
// uses the master view: UART receiver/transmitter strobes plus the external ALU.
interface uart_alu_interface_if #(
  parameter int NBITS    = 8,
  parameter int NBITS_OP = 6
);
  logic                rx_done_tick;
  logic [NBITS-1:0]    data_rx;
  logic                tx_done_tick;
  logic [NBITS-1:0]    alu_result;
  logic [NBITS-1:0]    operand_a;
  logic [NBITS-1:0]    operand_b;
  logic [NBITS_OP-1:0] opcode;
  logic                tx_start;
  logic [NBITS-1:0]    data_tx;
  logic                busy;
  logic                frame_timeout;
  logic                rx_overrun;

  modport slave (
    input  rx_done_tick, data_rx, tx_done_tick, alu_result,
    output operand_a, operand_b, opcode, tx_start, data_tx,
           busy, frame_timeout, rx_overrun
  );

  modport master (
    output rx_done_tick, data_rx, tx_done_tick, alu_result,
    input  operand_a, operand_b, opcode, tx_start, data_tx,
           busy, frame_timeout, rx_overrun
  );
endinterface

// File: rtl/uart_alu_interface.sv
// Host-side sequencer for a UART-attached ALU.
// Received bytes are assembled into a frame (operand A, operand B, opcode).
// The latched frame drives an external combinational ALU. One cycle later the
// ALU result is handed to the UART transmitter with a single-cycle tx_start.
// A watchdog abandons a partial frame that stalls for TIMEOUT_CYCLES clocks.
module uart_alu_interface #(
  parameter int NBITS          = 8,
  parameter int NBITS_OP       = 6,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int TIMEOUT_BITS   = 27
) (
  input  logic                 CLK_100MHZ,
  input  logic                 reset,
  uart_alu_interface_if.slave  bus
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_t;

  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST =
    WD_EN ? TIMEOUT_BITS'(TIMEOUT_CYCLES - 1) : '0;

  state_t                state_q;
  logic [NBITS-1:0]      operand_a_q;
  logic [NBITS-1:0]      operand_b_q;
  logic [NBITS_OP-1:0]   opcode_q;
  logic [NBITS-1:0]      data_tx_q;
  logic                  tx_start_q;
  logic                  frame_timeout_q;
  logic                  rx_overrun_q;
  logic [TIMEOUT_BITS-1:0] wd_q;

  logic in_frame;
  logic wd_expire;

  // A partial frame is in progress only while waiting for B or the opcode.
  // An arriving byte always beats the watchdog in the same cycle.
  always_comb begin
    in_frame  = (state_q == WAIT_B) || (state_q == WAIT_OP);
    wd_expire = WD_EN && in_frame && !bus.rx_done_tick && (wd_q == WD_LAST);
  end

  // Watchdog: counts idle cycles inside a partial frame and clears otherwise.
  always_ff @(posedge CLK_100MHZ or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
    end else if (!WD_EN || !in_frame || bus.rx_done_tick || wd_expire) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + TIMEOUT_BITS'(1);
    end
  end

  // Frame sequencer with registered outputs; strobes default low every cycle.
  always_ff @(posedge CLK_100MHZ or posedge reset) begin
    if (reset) begin
      state_q         <= WAIT_A;
      operand_a_q     <= '0;
      operand_b_q     <= '0;
      opcode_q        <= '0;
      data_tx_q       <= '0;
      tx_start_q      <= 1'b0;
      frame_timeout_q <= 1'b0;
      rx_overrun_q    <= 1'b0;
    end else begin
      tx_start_q      <= 1'b0;
      frame_timeout_q <= 1'b0;
      case (state_q)
        WAIT_A: begin
          if (bus.rx_done_tick) begin
            operand_a_q <= bus.data_rx;
            state_q     <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (bus.rx_done_tick) begin
            operand_b_q <= bus.data_rx;
            state_q     <= WAIT_OP;
          end else if (wd_expire) begin
            frame_timeout_q <= 1'b1;
            state_q         <= WAIT_A;
          end
        end
        WAIT_OP: begin
          if (bus.rx_done_tick) begin
            opcode_q <= bus.data_rx[NBITS_OP-1:0];
            state_q  <= SEND;
          end else if (wd_expire) begin
            frame_timeout_q <= 1'b1;
            state_q         <= WAIT_A;
          end
        end
        SEND: begin
          data_tx_q  <= bus.alu_result;
          tx_start_q <= 1'b1;
          state_q    <= WAIT_TX;
          if (bus.rx_done_tick) begin
            rx_overrun_q <= 1'b1;
          end
        end
        WAIT_TX: begin
          // A byte coinciding with the end of transmission opens the next frame.
          if (bus.tx_done_tick) begin
            if (bus.rx_done_tick) begin
              operand_a_q <= bus.data_rx;
              state_q     <= WAIT_B;
            end else begin
              state_q <= WAIT_A;
            end
          end else if (bus.rx_done_tick) begin
            rx_overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q <= WAIT_A;
        end
      endcase
    end
  end

  // Output mapping; busy is decoded directly from the state register.
  always_comb begin
    bus.operand_a     = operand_a_q;
    bus.operand_b     = operand_b_q;
    bus.opcode        = opcode_q;
    bus.data_tx       = data_tx_q;
    bus.tx_start      = tx_start_q;
    bus.frame_timeout = frame_timeout_q;
    bus.rx_overrun    = rx_overrun_q;
    bus.busy          = (state_q == SEND) || (state_q == WAIT_TX);
  end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Self-checking bench for uart_alu_interface with a 50-cycle watchdog.
module tb_uart_alu_interface;
  localparam int NB  = 8;
  localparam int NOP = 6;
  localparam int TO  = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   ts_cnt = 0;
  int   ft_cnt = 0;

  uart_alu_interface_if #(.NBITS(NB), .NBITS_OP(NOP)) bus ();

  uart_alu_interface #(
    .NBITS(NB), .NBITS_OP(NOP), .TIMEOUT_CYCLES(TO), .TIMEOUT_BITS(6)
  ) dut (
    .CLK_100MHZ(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // External ALU model.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return ~(a + b);
    endcase
  endfunction

  assign bus.alu_result = alu_ref(bus.operand_a, bus.operand_b, bus.opcode);

  // Pulse counters: at a rising edge these read the value held in the previous cycle.
  always @(posedge clk) begin
    if (bus.tx_start) ts_cnt++;
    if (bus.frame_timeout) ft_cnt++;
  end

  // Stimulus helpers; each is entered and left at a falling edge.
  task automatic pulse_rx(input logic [7:0] b);
    bus.rx_done_tick = 1'b1; bus.data_rx = b;
    @(negedge clk);
    bus.rx_done_tick = 1'b0; bus.data_rx = 8'($urandom);
  endtask

  task automatic pulse_tx_done();
    bus.tx_done_tick = 1'b1;
    @(negedge clk);
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic pulse_both(input logic [7:0] b);
    bus.rx_done_tick = 1'b1; bus.tx_done_tick = 1'b1; bus.data_rx = b;
    @(negedge clk);
    bus.rx_done_tick = 1'b0; bus.tx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns the number of cycles until tx_start is seen, or -1 within a bounded window.
  task automatic wait_tx_start(output int lat);
    bit seen;
    lat = -1; seen = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (!seen) begin
        @(negedge clk);
        if (bus.tx_start) begin lat = i; seen = 1'b1; end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if ({bus.operand_a, bus.operand_b, bus.opcode, bus.data_tx} !== 30'h0) begin
      errors++; $display("FAIL reset_regs: got %h expected 0",
                         {bus.operand_a, bus.operand_b, bus.opcode, bus.data_tx}); end
    checks++; if ({bus.tx_start, bus.busy, bus.frame_timeout, bus.rx_overrun} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000",
                         {bus.tx_start, bus.busy, bus.frame_timeout, bus.rx_overrun}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy_after: got %b expected 0", bus.busy); end
  endtask

  task automatic test_basic_add();
    int lat; int ts0;
    ts0 = ts_cnt;
    pulse_rx(8'h05); pulse_rx(8'h03); pulse_rx(8'h20);
    checks++; if (bus.operand_a !== 8'h05) begin
      errors++; $display("FAIL basic_a: got %h expected 05", bus.operand_a); end
    checks++; if (bus.operand_b !== 8'h03) begin
      errors++; $display("FAIL basic_b: got %h expected 03", bus.operand_b); end
    checks++; if (bus.opcode !== 6'h20) begin
      errors++; $display("FAIL basic_op: got %h expected 20", bus.opcode); end
    checks++; if (bus.busy !== 1'b1 || bus.tx_start !== 1'b0) begin
      errors++; $display("FAIL basic_send_phase: got busy=%b tx_start=%b expected 1 0",
                         bus.busy, bus.tx_start); end
    wait_tx_start(lat);
    checks++; if (lat != 1) begin
      errors++; $display("FAIL basic_latency: got %0d expected 1", lat); end
    checks++; if (bus.data_tx !== 8'h08) begin
      errors++; $display("FAIL basic_data_tx: got %h expected 08", bus.data_tx); end
    @(negedge clk);
    checks++; if (bus.tx_start !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL basic_pulse_end: got tx_start=%b busy=%b expected 0 1",
                         bus.tx_start, bus.busy); end
    idle(5);
    checks++; if (bus.data_tx !== 8'h08) begin
      errors++; $display("FAIL basic_hold: got %h expected 08", bus.data_tx); end
    pulse_tx_done();
    checks++; if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle: got busy=%b expected 0", bus.busy); end
    checks++; if (ts_cnt - ts0 != 1) begin
      errors++; $display("FAIL basic_pulse_count: got %0d expected 1", ts_cnt - ts0); end
  endtask

  task automatic test_opcode_mask();
    int lat;
    pulse_rx(8'h10); pulse_rx(8'h20); pulse_rx(8'hE2);
    checks++; if (bus.opcode !== 6'h22) begin
      errors++; $display("FAIL mask_op: got %h expected 22", bus.opcode); end
    wait_tx_start(lat);
    checks++; if (lat != 1 || bus.data_tx !== 8'hF0) begin
      errors++; $display("FAIL mask_result: got lat=%0d data=%h expected 1 f0", lat, bus.data_tx); end
    pulse_tx_done();
  endtask

  task automatic test_overrun();
    int lat;
    pulse_rx(8'h30); pulse_rx(8'h12); pulse_rx(8'h26);
    wait_tx_start(lat);
    pulse_rx(8'h7F);
    checks++; if (bus.rx_overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_flag: got %b expected 1", bus.rx_overrun); end
    checks++; if (bus.operand_a !== 8'h30 || bus.busy !== 1'b1 || bus.data_tx !== 8'h22) begin
      errors++; $display("FAIL ovr_unchanged: got a=%h busy=%b data=%h expected 30 1 22",
                         bus.operand_a, bus.busy, bus.data_tx); end
    pulse_tx_done();
    pulse_rx(8'h09); pulse_rx(8'h04); pulse_rx(8'h22);
    wait_tx_start(lat);
    checks++; if (lat != 1 || bus.data_tx !== 8'h05 || bus.operand_a !== 8'h09) begin
      errors++; $display("FAIL ovr_next_frame: got lat=%0d data=%h a=%h expected 1 05 09",
                         lat, bus.data_tx, bus.operand_a); end
    pulse_tx_done();
    checks++; if (bus.rx_overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_sticky: got %b expected 1", bus.rx_overrun); end
  endtask

  task automatic test_simultaneous();
    int lat;
    apply_reset();
    pulse_rx(8'h44); pulse_rx(8'h11); pulse_rx(8'h20);
    wait_tx_start(lat);
    idle(2);
    pulse_both(8'h11);
    checks++; if (bus.operand_a !== 8'h11 || bus.busy !== 1'b0 || bus.rx_overrun !== 1'b0) begin
      errors++; $display("FAIL simul_accept: got a=%h busy=%b ovr=%b expected 11 0 0",
                         bus.operand_a, bus.busy, bus.rx_overrun); end
    pulse_rx(8'h22); pulse_rx(8'h20);
    checks++; if (bus.busy !== 1'b1 || bus.operand_b !== 8'h22) begin
      errors++; $display("FAIL simul_wait_b: got busy=%b b=%h expected 1 22", bus.busy, bus.operand_b); end
    wait_tx_start(lat);
    checks++; if (lat != 1 || bus.data_tx !== 8'h33) begin
      errors++; $display("FAIL simul_result: got lat=%0d data=%h expected 1 33", lat, bus.data_tx); end
    pulse_tx_done();
  endtask

  task automatic test_timeout();
    int lat; int ft0; int seen;
    ft0 = ft_cnt; seen = -1;
    pulse_rx(8'h01);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.frame_timeout && seen < 0) seen = i;
    end
    checks++; if (seen != TO) begin
      errors++; $display("FAIL to_position: got %0d expected %0d", seen, TO); end
    checks++; if (ft_cnt - ft0 != 1) begin
      errors++; $display("FAIL to_pulse_count: got %0d expected 1", ft_cnt - ft0); end
    pulse_rx(8'h0A); pulse_rx(8'h0B); pulse_rx(8'h20);
    wait_tx_start(lat);
    checks++; if (lat != 1 || bus.data_tx !== 8'h15 || bus.operand_a !== 8'h0A) begin
      errors++; $display("FAIL to_fresh_frame: got lat=%0d data=%h a=%h expected 1 15 0a",
                         lat, bus.data_tx, bus.operand_a); end
    pulse_tx_done();
    // A byte on the last allowed cycle must keep the frame alive.
    ft0 = ft_cnt;
    pulse_rx(8'h02);
    idle(TO - 1);
    pulse_rx(8'h5C);
    idle(3);
    checks++; if (ft_cnt - ft0 != 0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL to_near_miss: got pulses=%0d busy=%b expected 0 0",
                         ft_cnt - ft0, bus.busy); end
    pulse_rx(8'h25);
    checks++; if (bus.busy !== 1'b1 || bus.operand_a !== 8'h02 || bus.operand_b !== 8'h5C) begin
      errors++; $display("FAIL to_near_miss_state: got busy=%b a=%h b=%h expected 1 02 5c",
                         bus.busy, bus.operand_a, bus.operand_b); end
    wait_tx_start(lat);
    checks++; if (lat != 1 || bus.data_tx !== 8'h5E) begin
      errors++; $display("FAIL to_near_miss_result: got lat=%0d data=%h expected 1 5e", lat, bus.data_tx); end
    pulse_tx_done();
  endtask

  task automatic test_reset_mid_tx();
    int lat;
    pulse_rx(8'h7E); pulse_rx(8'h01); pulse_rx(8'h20);
    wait_tx_start(lat);
    pulse_rx(8'h55);
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.tx_start, bus.data_tx, bus.operand_a, bus.operand_b, bus.opcode} !== 31'h0) begin
      errors++; $display("FAIL rstmid_regs: got %h expected 0",
                         {bus.tx_start, bus.data_tx, bus.operand_a, bus.operand_b, bus.opcode}); end
    checks++; if ({bus.busy, bus.rx_overrun, bus.frame_timeout} !== 3'b0) begin
      errors++; $display("FAIL rstmid_flags: got %b expected 000",
                         {bus.busy, bus.rx_overrun, bus.frame_timeout}); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_rx(8'h21); pulse_rx(8'h21); pulse_rx(8'h20);
    wait_tx_start(lat);
    checks++; if (lat != 1 || bus.data_tx !== 8'h42) begin
      errors++; $display("FAIL rstmid_after: got lat=%0d data=%h expected 1 42", lat, bus.data_tx); end
    pulse_tx_done();
    checks++; if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: got busy=%b expected 0", bus.busy); end
  endtask

  // Random frames with random gaps, including back-to-back bytes and stray bytes while busy.
  task automatic test_random_frames();
    logic [5:0] ops [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};
    logic [7:0] a, b, op, exp;
    bit m_ovr;
    int lat, ts0;
    apply_reset();
    m_ovr = 1'b0;
    for (int f = 0; f < 25; f++) begin
      a  = 8'($urandom); b = 8'($urandom); op = 8'($urandom);
      if ($urandom_range(0, 1) == 1) op[5:0] = ops[$urandom_range(0, 4)];
      exp = alu_ref(a, b, op[5:0]);
      ts0 = ts_cnt;
      pulse_rx(a); idle($urandom_range(0, 10));
      pulse_rx(b); idle($urandom_range(0, 10));
      pulse_rx(op);
      wait_tx_start(lat);
      checks++; if (lat != 1 || bus.data_tx !== exp) begin
        errors++; $display("FAIL rand_result[%0d]: got lat=%0d data=%h expected 1 %h", f, lat, bus.data_tx, exp); end
      checks++; if (bus.operand_a !== a || bus.operand_b !== b || bus.opcode !== op[5:0]) begin
        errors++; $display("FAIL rand_operands[%0d]: got %h %h %h expected %h %h %h", f,
                           bus.operand_a, bus.operand_b, bus.opcode, a, b, op[5:0]); end
      if ($urandom_range(0, 3) == 0) begin
        pulse_rx(8'($urandom));
        m_ovr = 1'b1;
      end
      idle($urandom_range(0, 6));
      checks++; if (bus.data_tx !== exp || bus.operand_a !== a) begin
        errors++; $display("FAIL rand_hold[%0d]: got data=%h a=%h expected %h %h", f, bus.data_tx, bus.operand_a, exp, a); end
      pulse_tx_done();
      checks++; if (bus.busy !== 1'b0 || bus.rx_overrun !== m_ovr || ts_cnt - ts0 != 1) begin
        errors++; $display("FAIL rand_end[%0d]: got busy=%b ovr=%b pulses=%0d expected 0 %b 1", f,
                           bus.busy, bus.rx_overrun, ts_cnt - ts0, m_ovr); end
    end
  endtask

  initial begin
    bus.rx_done_tick = 1'b0;
    bus.tx_done_tick = 1'b0;
    bus.data_rx      = '0;
    test_reset();
    test_basic_add();
    test_opcode_mask();
    test_overrun();
    test_simultaneous();
    test_timeout();
    test_reset_mid_tx();
    test_random_frames();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion expected finish before limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end
endmodule

// File: doc/uart_alu_interface.md
Name: uart_alu_interface

Overview:
- Host-side sequencer on the parallel side of the UART block.
- Consumes received bytes as a 3-byte command frame: operand A, operand B, opcode.
- Presents the latched operands and opcode to an external combinational ALU, then hands the ALU result back to the UART transmitter using a single-cycle tx_start pulse.
- Watchdog returns a stalled partial frame to idle.

Parameters:
- NBITS, 8: data byte / operand / result width.
- NBITS_OP, 6: opcode width; taken from data_rx[NBITS_OP-1:0], upper bits ignored.
- TIMEOUT_CYCLES, 100000000: idle clocks allowed inside a partial frame before abort; 0 disables the watchdog.
- TIMEOUT_BITS, 27: watchdog counter width; must satisfy 2^TIMEOUT_BITS > TIMEOUT_CYCLES.

Ports:
- CLK_100MHZ  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_done_tick  input  1  one-cycle strobe from UART receiver; data_rx valid in the same cycle.
- data_rx  input  NBITS  received byte.
- tx_done_tick  input  1  one-cycle strobe from UART transmitter at the end of the stop bit.
- alu_result  input  NBITS  combinational ALU output for the current operand_a/operand_b/opcode.
- operand_a  output  NBITS  latched operand A (registered).
- operand_b  output  NBITS  latched operand B (registered).
- opcode  output  NBITS_OP  latched opcode (registered).
- tx_start  output  1  one-cycle start strobe to the UART transmitter (registered).
- data_tx  output  NBITS  byte to transmit, held stable from tx_start until tx_done_tick (registered).
- busy  output  1  high in SEND and WAIT_TX (decoded from state).
- frame_timeout  output  1  one-cycle pulse when the watchdog aborts a frame (registered).
- rx_overrun  output  1  sticky flag: a byte arrived while busy; cleared only by reset.

Behaviour:
- Reset (async, immediate):
  - state = WAIT_A.
  - operand_a, operand_b, opcode, data_tx, tx_start, frame_timeout, rx_overrun = 0.
  - Watchdog counter = 0.
- States: WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX.
- WAIT_A: on rx_done_tick, operand_a <= data_rx, go to WAIT_B.
- WAIT_B: on rx_done_tick, operand_b <= data_rx, go to WAIT_OP.
- WAIT_OP: on rx_done_tick, opcode <= data_rx[NBITS_OP-1:0], go to SEND.
- SEND, one cycle only:
  - data_tx <= alu_result, tx_start <= 1, go to WAIT_TX.
  - alu_result is sampled one full cycle after opcode is latched, so the ALU has a whole cycle to settle.
- WAIT_TX:
  - tx_start <= 0 on the first edge in this state, so tx_start is high for exactly one cycle.
  - data_tx is held.
  - On tx_done_tick, go to WAIT_A.
- Latency: opcode strobe sampled at edge k; tx_start high between edges k+1 and k+2.
- Operand and opcode registers hold their values until overwritten; they are not cleared at frame end.
- tx_done_tick outside WAIT_TX is ignored.
- rx_done_tick in SEND, or in WAIT_TX without a simultaneous tx_done_tick:
  - Byte is dropped and rx_overrun <= 1.
  - State and operands are unchanged.
- rx_done_tick and tx_done_tick in the same cycle in WAIT_TX:
  - Frame completes and the byte is accepted as the new operand A.
  - Next state is WAIT_B; rx_overrun is not set.
- Watchdog (only when TIMEOUT_CYCLES != 0):
  - Counter clears on every rx_done_tick and in every state other than WAIT_B/WAIT_OP.
  - Counter increments each cycle in WAIT_B/WAIT_OP with no rx_done_tick.
  - When the counter equals TIMEOUT_CYCLES-1 with no rx_done_tick, the next edge sets state = WAIT_A, counter = 0 and frame_timeout = 1 for one cycle.
  - If rx_done_tick arrives in that same cycle, the byte wins: normal advance, no timeout.
- frame_timeout is 0 in every cycle except the abort pulse.
- Reset mid-transmission: tx_start and data_tx go to 0 immediately. The UART transmitter is reset by the same signal, so no partial byte needs handling here.

Test Plan:
- Frame 0x05, 0x03, opcode 0x20 with the ALU model doing add: operand_a=0x05, operand_b=0x03, opcode=0x20; tx_start is a single-cycle pulse 1 cycle after the opcode strobe; data_tx=0x08, held until tx_done_tick; busy high from SEND through WAIT_TX; state returns to WAIT_A.
- Opcode byte 0xE2 -> opcode=6'h22; upper bits discarded.
- Extra byte 0x7F during WAIT_TX -> rx_overrun=1 (sticky); operand_a keeps its old value; the next frame still completes and rx_overrun stays 1 until reset.
- rx_done_tick with data 0x11 in the same cycle as tx_done_tick -> operand_a=0x11, state WAIT_B, rx_overrun=0.
- TIMEOUT_CYCLES=50: send 0x01 only, then idle -> frame_timeout pulses once, 50 cycles after the strobe; a following 3-byte frame is decoded from a fresh operand A. Repeat with a byte landing exactly on cycle 50 -> no timeout, state WAIT_OP.
- Assert reset in the cycle after tx_start, during WAIT_TX -> all outputs 0 asynchronously, state WAIT_A; a subsequent full frame works normally.
